shared_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single data-memory port among the processing cores of the multicore matrix-multiplication array. Each core posts a read or write request; the arbiter serialises them onto the synchronous block RAM and routes read data back to the owning core. It sits between the core address-select paths and the shared data memory.

---
 rtl/shared_mem_arb_pkg.sv | 21 ++
 rtl/shared_mem_arbiter_rr_pick.sv | 32 +++
 rtl/shared_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_shared_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/shared_mem_arb_pkg.sv
// Shared declarations for the shared-memory arbiter: FSM state encoding and
// default geometry matching the matrix-multiplication core array.
package shared_mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 8;

  // Width of a core index; never zero so ports stay legal for small arrays.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_pick.sv
// Combinational round-robin picker. The search starts one position after
// ptr and wraps, so the most recent winner has the lowest priority.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan candidates ptr+1 .. ptr+N (mod N); the first requester wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 1; off <= N; off++) begin
      int cand;
      cand = (int'(ptr) + off) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter serialising per-core read/write requests onto a single
// synchronous block-RAM port and returning read data to the owning core.
// A write occupies IDLE->ACCESS (2 cycles); a read IDLE->ACCESS->RDATA (3).
module shared_mem_arbiter
  import shared_mem_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int IDX_W = idx_width(NUM_CORES);

  arb_state_t state, next_state;

  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     owner;
  logic [NUM_CORES-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 start;
  logic                 capture;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_we;

  rr_pick #(
    .N     (NUM_CORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (core_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values, independent of block ordering.
      state <= next_state;
    end
  end

  // Next-state: requests are only looked at in IDLE; the registered write
  // enable tells ACCESS whether the owner's operation was a read or a write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_any) next_state = ACCESS;
      ACCESS:  next_state = mem_we ? IDLE : RDATA;
      RDATA:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: launch an access from IDLE, capture read data in RDATA,
  // and select the winning core's address/data/direction for registering.
  always_comb begin
    start     = 1'b0;
    capture   = 1'b0;
    busy      = 1'b1;
    sel_addr  = core_addr[pick_idx*ADDR_W +: ADDR_W];
    sel_wdata = core_wdata[pick_idx*DATA_W +: DATA_W];
    sel_we    = core_we[pick_idx];
    case (state)
      IDLE: begin
        busy  = 1'b0;
        start = pick_any;
      end
      RDATA:   capture = 1'b1;
      default: ;
    endcase
  end

  // Registered datapath: grant and rvalid are single-cycle pulses, mem_we is
  // high only in the ACCESS cycle, address/data hold until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= IDX_W'(NUM_CORES - 1);
      owner       <= '0;
      core_gnt    <= '0;
      core_rvalid <= '0;
      core_rdata  <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
    end else begin
      core_gnt    <= '0;
      core_rvalid <= '0;
      mem_we      <= 1'b0;
      if (start) begin
        owner     <= pick_idx;
        ptr       <= pick_idx;
        core_gnt  <= pick_gnt;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        mem_we    <= sel_we;
      end
      if (capture) begin
        core_rdata  <= mem_rdata;
        core_rvalid <= NUM_CORES'(1) << owner;
      end
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural read-first BRAM.
module tb_shared_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    core_req;
  logic [NC-1:0]    core_we;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [NC-1:0]    core_gnt;
  logic [NC-1:0]    core_rvalid;
  logic [DW-1:0]    core_rdata;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_we;
  logic [DW-1:0]    mem_rdata;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:65535];

  shared_mem_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Synchronous block RAM, read-first, one-cycle read latency
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    check("gnt_onehot0",    32'($onehot0(core_gnt)),    32'd1);
    check("rvalid_onehot0", 32'($onehot0(core_rvalid)), 32'd1);
  endtask

  task automatic set_core(input int i, input logic req, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req[i]          = req;
    core_we[i]           = we;
    core_addr[i*AW +: AW] = a;
    core_wdata[i*DW +: DW] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},    32'(core_gnt),    32'h0);
    check({tag, "_rvalid"}, 32'(core_rvalid), 32'h0);
    check({tag, "_rdata"},  32'(core_rdata),  32'h0);
    check({tag, "_addr"},   32'(mem_addr),    32'h0);
    check({tag, "_wdata"},  32'(mem_wdata),   32'h0);
    check({tag, "_we"},     32'(mem_we),      32'h0);
    check({tag, "_busy"},   32'(busy),        32'h0);
  endtask

  logic [NC-1:0] fair_exp [4];

  initial begin
    rst        = 1'b1;
    core_req   = '0;
    core_we    = '0;
    core_addr  = '0;
    core_wdata = '0;
    for (int i = 0; i < 4; i++) mem[16'h0100 + i] = 8'hC0 + 8'(i);
    fair_exp[0] = 4'b0001;
    fair_exp[1] = 4'b1000;
    fair_exp[2] = 4'b0001;
    fair_exp[3] = 4'b1000;

    // Reset state
    #12;
    check_idle_outputs("reset");
    rst = 1'b0;

    // Single write: core 2, addr 0x0040, data 0xA5
    set_core(2, 1'b1, 1'b1, 16'h0040, 8'hA5);
    step();
    check("wr_gnt",   32'(core_gnt),  32'h4);
    check("wr_we",    32'(mem_we),    32'h1);
    check("wr_addr",  32'(mem_addr),  32'h0040);
    check("wr_wdata", 32'(mem_wdata), 32'hA5);
    check("wr_busy",  32'(busy),      32'h1);
    set_core(2, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    check("wr_gnt_end", 32'(core_gnt), 32'h0);
    check("wr_we_end",  32'(mem_we),   32'h0);
    check("wr_busy_end", 32'(busy),    32'h0);

    // Single read: core 1 reads back 0x0040
    set_core(1, 1'b1, 1'b0, 16'h0040, 8'h00);
    step();
    check("rd_gnt",  32'(core_gnt), 32'h2);
    check("rd_we",   32'(mem_we),   32'h0);
    check("rd_addr", 32'(mem_addr), 32'h0040);
    set_core(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    check("rd_rvalid_c2", 32'(core_rvalid), 32'h0);
    check("rd_busy_c2",   32'(busy),        32'h1);
    step();
    check("rd_rvalid_c3", 32'(core_rvalid), 32'h2);
    check("rd_rdata_c3",  32'(core_rdata),  32'hA5);
    check("rd_busy_c3",   32'(busy),        32'h0);
    step();
    check("rd_rvalid_c4", 32'(core_rvalid), 32'h0);

    // Contention from reset: all four read, expect order 0,1,2,3
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NC; i++) set_core(i, 1'b1, 1'b0, 16'h0100 + 16'(i), 8'h00);
    for (int k = 0; k < NC; k++) begin
      step();
      check("cont_gnt", 32'(core_gnt), 32'(1 << k));
      set_core(k, 1'b0, 1'b0, 16'h0000, 8'h00);
      step();
      check("cont_gnt_quiet", 32'(core_gnt), 32'h0);
      step();
      check("cont_rvalid", 32'(core_rvalid), 32'(1 << k));
      check("cont_rdata",  32'(core_rdata),  32'hC0 + 32'(k));
    end

    // Fairness: cores 0 and 3 write continuously, grants alternate 0,3,0,3
    set_core(0, 1'b1, 1'b1, 16'h0080, 8'h5A);
    set_core(3, 1'b1, 1'b1, 16'h0083, 8'h3C);
    for (int j = 0; j < 4; j++) begin
      step();
      check("fair_gnt", 32'(core_gnt), 32'(fair_exp[j]));
      step();
      check("fair_gnt_access", 32'(core_gnt), 32'h0);
    end
    set_core(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_core(3, 1'b0, 1'b0, 16'h0000, 8'h00);

    // Withdrawal: core 1 requests only while core 0's read is in flight
    set_core(0, 1'b1, 1'b0, 16'h0100, 8'h00);
    step();
    check("wd_gnt0", 32'(core_gnt), 32'h1);
    set_core(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_core(1, 1'b1, 1'b0, 16'h0101, 8'h00);
    step();
    check("wd_gnt_access", 32'(core_gnt), 32'h0);
    step();
    check("wd_rvalid", 32'(core_rvalid), 32'h1);
    check("wd_rdata",  32'(core_rdata),  32'hC0);
    set_core(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    check("wd_no_gnt1", 32'(core_gnt), 32'h0);
    check("wd_busy",    32'(busy),     32'h0);
    step();
    check("wd_no_gnt2", 32'(core_gnt), 32'h0);

    // Reset during a write's ACCESS cycle: mem_we drops immediately
    set_core(1, 1'b1, 1'b1, 16'h0300, 8'hEE);
    step();
    check("rw_we", 32'(mem_we), 32'h1);
    set_core(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    rst = 1'b1;
    #1;
    check("rw_we_reset", 32'(mem_we), 32'h0);
    step();
    rst = 1'b0;

    // Reset during a read's ACCESS cycle: no rvalid afterwards
    set_core(2, 1'b1, 1'b0, 16'h0102, 8'h00);
    step();
    check("rr_gnt", 32'(core_gnt), 32'h4);
    set_core(2, 1'b0, 1'b0, 16'h0000, 8'h00);
    rst = 1'b1;
    #1;
    check_idle_outputs("rr_reset");
    step();
    rst = 1'b0;
    step();
    check("rr_rvalid_a", 32'(core_rvalid), 32'h0);
    step();
    check("rr_rvalid_b", 32'(core_rvalid), 32'h0);
    check("rr_rdata_b",  32'(core_rdata),  32'h0);

    // After reset the pointer restarts: core 0 beats core 3
    set_core(0, 1'b1, 1'b1, 16'h0200, 8'h77);
    set_core(3, 1'b1, 1'b1, 16'h0203, 8'h88);
    step();
    check("post_reset_gnt", 32'(core_gnt), 32'h1);
    set_core(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_core(3, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    check("post_reset_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
